instr_sequencer: RTL

Multi-cycle fetch/decode/execute sequencer that drives the clock enables of the datapath's `register` instances. It walks an asynchronous-read program ROM, decodes 8-bit instructions, and produces one-hot register load strobes, a data-source select, an immediate value and an ALU opcode for the datapath. It sits directly upstream of the register bank: each register's CE is one bit of `REG_CE`, and its IN is the datapath mux selected by `DATA_SEL`.

---
 rtl/instr_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Fetch/decode/execute sequencer that walks an asynchronous-read program
//   ROM and drives the load strobes and source selects of a 4-entry
//   register bank.
//
// Parameters
//   PC_WIDTH : program counter / ROM address width (1..8)
//   WIDTH    : immediate width (operand byte zero-extended or truncated)
//
// Ports
//   CLK      in   rising-edge clock
//   RST      in   synchronous active-high reset
//   HOLD     in   freeze all state; forces REG_CE and ILLEGAL low
//   ROM_DATA in   program word at ROM_ADDR (combinational)
//   ROM_ADDR out  current PC
//   REG_CE   out  one-hot load strobe for r0..r3 (EXEC only)
//   DATA_SEL out  00 immediate, 01 register SRC_SEL, 10 ALU result
//   SRC_SEL  out  rs field of the instruction register
//   DST_SEL  out  rd field of the instruction register (ALU A operand)
//   ALU_OP   out  00 ADD, 01 SUB, 10 AND, 11 OR
//   IMM      out  operand byte latched in FETCH2
//   HALTED   out  high while in HALT
//   ILLEGAL  out  one-cycle pulse in EXEC for an undefined opcode
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int WIDTH    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                HOLD,
    input  logic [7:0]          ROM_DATA,
    output logic [PC_WIDTH-1:0] ROM_ADDR,
    output logic [3:0]          REG_CE,
    output logic [1:0]          DATA_SEL,
    output logic [1:0]          SRC_SEL,
    output logic [1:0]          DST_SEL,
    output logic [1:0]          ALU_OP,
    output logic [WIDTH-1:0]    IMM,
    output logic                HALTED,
    output logic                ILLEGAL
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(1);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [7:0]          opr_q, opr_d;

    logic is_nop, is_ldi, is_mov, is_alu, is_jmp, is_hlt, is_ill;
    logic exec_live;

    // Instruction class decode from the instruction register.
    always_comb begin
        is_nop = (ir_q == 8'h00);
        is_ldi = (ir_q[7:2] == 6'b000100);
        is_mov = (ir_q[7:4] == 4'b0010);
        is_alu = (ir_q[7:6] == 2'b01);
        is_jmp = (ir_q == 8'h80);
        is_hlt = (ir_q == 8'hFF);
        is_ill = !(is_nop || is_ldi || is_mov || is_alu || is_jmp || is_hlt);
    end

    // Next-state logic; HOLD simply keeps every register at its value.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
        if (!HOLD) begin
            case (state_q)
                S_FETCH: begin
                    ir_d    = ROM_DATA;
                    pc_d    = pc_q + PC_INC;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (is_ldi || is_jmp) begin
                        state_d = S_FETCH2;
                    end else if (is_hlt) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_FETCH2: begin
                    opr_d   = ROM_DATA;
                    pc_d    = pc_q + PC_INC;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    if (is_jmp) begin
                        pc_d = opr_q[PC_WIDTH-1:0];
                    end
                    state_d = S_FETCH;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            opr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
        end
    end

    // The strobe is gated by RST as well as HOLD so that a reset landing on
    // the EXEC edge never lets a register load alongside it.
    assign exec_live = (state_q == S_EXEC) && !HOLD && !RST;

    always_comb begin
        REG_CE = 4'b0000;
        if (exec_live && (is_ldi || is_mov || is_alu)) begin
            REG_CE = 4'b0001 << ir_q[1:0];
        end
        DATA_SEL = 2'b00;
        if (is_mov) begin
            DATA_SEL = 2'b01;
        end else if (is_alu) begin
            DATA_SEL = 2'b10;
        end
    end

    assign ILLEGAL  = exec_live && is_ill;
    assign SRC_SEL  = ir_q[3:2];
    assign DST_SEL  = ir_q[1:0];
    assign ALU_OP   = ir_q[5:4];
    assign IMM      = WIDTH'(opr_q);
    assign HALTED   = (state_q == S_HALT);
    assign ROM_ADDR = pc_q;

endmodule
